// File: rtl/traffic_light_monitor_if.sv
// Traffic-light output bus: the controller drives it (master), the monitor observes it (slave).
interface traffic_light_monitor_if;
  logic [1:0] ns_light;
  logic [1:0] ew_light;

  modport master (output ns_light, output ew_light);
  modport slave  (input  ns_light, input  ew_light);
endinterface

// File: rtl/traffic_light_monitor.sv
// Passive traffic-light protocol checker: codes, phase order, conflicts, dwell times.
// Dwell-time checks are built only when TLM_TIMING_CHECK_EN is defined.
module traffic_light_monitor #(
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned GREEN_MIN    = 4,
  parameter int unsigned GREEN_MAX    = 16,
  parameter int unsigned YELLOW_TICKS = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  traffic_light_monitor_if.slave        lights,
  input  logic                          clear_err,
  output logic                          conflict_err,
  output logic                          seq_err,
  output logic                          timing_err,
  output logic                          illegal_err,
  output logic                          err_pulse,
  output logic [15:0]                   cycle_count
);

  localparam logic [1:0] RED     = 2'b00;
  localparam logic [1:0] YELLOW  = 2'b01;
  localparam logic [1:0] GREEN   = 2'b10;
  localparam logic [1:0] ILLEGAL = 2'b11;

  if (GREEN_MIN > GREEN_MAX || YELLOW_TICKS == 0 || CNT_W < 2 ||
      GREEN_MAX >= (64'd1 << CNT_W) - 64'd1) begin : g_param_check
    $error("traffic_light_monitor: inconsistent dwell parameters");
  end

  function automatic logic legal_step(input logic [1:0] from, input logic [1:0] to);
    return (from == GREEN  && to == YELLOW) ||
           (from == YELLOW && to == RED)    ||
           (from == RED    && to == GREEN);
  endfunction

  logic       armed;
  logic [1:0] ns_prev, ew_prev;
  logic       ns_chg, ew_chg;
  logic       conflict_hit, seq_hit, illegal_hit, timing_hit, any_hit, cycle_inc;

  always_comb begin
    ns_chg       = armed && (lights.ns_light != ns_prev);
    ew_chg       = armed && (lights.ew_light != ew_prev);
    conflict_hit = (lights.ns_light != RED) && (lights.ew_light != RED);
    illegal_hit  = (lights.ns_light == ILLEGAL) || (lights.ew_light == ILLEGAL);
    seq_hit      = (ns_chg && !legal_step(ns_prev, lights.ns_light)) ||
                   (ew_chg && !legal_step(ew_prev, lights.ew_light));
    cycle_inc    = armed && (ns_prev == RED) && (lights.ns_light == GREEN);
    any_hit      = conflict_hit | seq_hit | illegal_hit | timing_hit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      armed        <= 1'b0;
      ns_prev      <= RED;
      ew_prev      <= RED;
      conflict_err <= 1'b0;
      seq_err      <= 1'b0;
      illegal_err  <= 1'b0;
      err_pulse    <= 1'b0;
      cycle_count  <= '0;
    end else begin
      armed        <= 1'b1;
      ns_prev      <= lights.ns_light;
      ew_prev      <= lights.ew_light;
      // A new hit outranks a simultaneous clear.
      conflict_err <= (conflict_err & ~clear_err) | conflict_hit;
      seq_err      <= (seq_err      & ~clear_err) | seq_hit;
      illegal_err  <= (illegal_err  & ~clear_err) | illegal_hit;
      err_pulse    <= any_hit;
      if (cycle_inc) cycle_count <= cycle_count + 16'd1;
    end
  end

`ifdef TLM_TIMING_CHECK_EN
  localparam logic [CNT_W-1:0] G_MIN_C = CNT_W'(GREEN_MIN);
  localparam logic [CNT_W-1:0] G_MAX_C = CNT_W'(GREEN_MAX);
  localparam logic [CNT_W-1:0] Y_C     = CNT_W'(YELLOW_TICKS);

  logic [CNT_W-1:0] ns_dwell, ew_dwell;

  // cnt is the dwell of prev, i.e. the phase being left on a change.
  function automatic logic dwell_viol(input logic armd, input logic chg,
                                      input logic [1:0] prev, input logic [1:0] cur,
                                      input logic [CNT_W-1:0] cnt);
    if (!armd) return 1'b0;
    if (chg)
      return (prev == GREEN  && (cnt < G_MIN_C || cnt > G_MAX_C)) ||
             (prev == YELLOW && cnt != Y_C);
    // Stall: fires only on the sample that takes dwell to GREEN_MAX+1.
    return (cur == GREEN) && (cnt == G_MAX_C);
  endfunction

  function automatic logic [CNT_W-1:0] next_dwell(input logic armd, input logic chg,
                                                  input logic [CNT_W-1:0] cnt);
    if (!armd || chg) return CNT_W'(1);
    return (cnt == '1) ? cnt : cnt + CNT_W'(1);
  endfunction

  always_comb
    timing_hit = dwell_viol(armed, ns_chg, ns_prev, lights.ns_light, ns_dwell) |
                 dwell_viol(armed, ew_chg, ew_prev, lights.ew_light, ew_dwell);

  always_ff @(posedge clk) begin
    if (reset) begin
      ns_dwell   <= '0;
      ew_dwell   <= '0;
      timing_err <= 1'b0;
    end else begin
      ns_dwell   <= next_dwell(armed, ns_chg, ns_dwell);
      ew_dwell   <= next_dwell(armed, ew_chg, ew_dwell);
      timing_err <= (timing_err & ~clear_err) | timing_hit;
    end
  end
`else
  always_comb timing_hit = 1'b0;
  assign timing_err = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed, table-driven bench for traffic_light_monitor; timing expectations follow TLM_TIMING_CHECK_EN.
module tb_traffic_light_monitor;

`ifdef TLM_TIMING_CHECK_EN
  localparam bit TON = 1'b1;
`else
  localparam bit TON = 1'b0;
`endif

  localparam logic [1:0] R = 2'b00, Y = 2'b01, G = 2'b10, X = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear_err;
  logic        conflict_err, seq_err, timing_err, illegal_err, err_pulse;
  logic [15:0] cycle_count;

  traffic_light_monitor_if lights ();

  traffic_light_monitor #(
    .CNT_W(8), .GREEN_MIN(4), .GREEN_MAX(16), .YELLOW_TICKS(2)
  ) dut (
    .clk(clk), .reset(reset), .lights(lights), .clear_err(clear_err),
    .conflict_err(conflict_err), .seq_err(seq_err), .timing_err(timing_err),
    .illegal_err(illegal_err), .err_pulse(err_pulse), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  // flags = {conflict, seq, timing, illegal, pulse}
  typedef struct {
    string       name;
    logic [1:0]  ns, ew;
    logic        clr, rst;
    logic [4:0]  flags;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   ec    = 0;

  function automatic logic [4:0] f(input bit c, input bit s, input bit t,
                                   input bit i, input bit p);
    return {c, s, t, i, p};
  endfunction

  function automatic void add(input string nm, input logic [1:0] ns, input logic [1:0] ew,
                              input bit clr, input bit rst, input logic [4:0] fl,
                              input int cnt);
    vec_t v;
    v.name = nm; v.ns = ns; v.ew = ew; v.clr = clr; v.rst = rst;
    v.flags = fl; v.cnt = 16'(cnt);
    tbl.push_back(v);
  endfunction

  task automatic apply(input vec_t v);
    logic [20:0] act, exp;
    lights.ns_light = v.ns;
    lights.ew_light = v.ew;
    clear_err       = v.clr;
    reset           = v.rst;
    @(posedge clk);
    #1;
    act = {conflict_err, seq_err, timing_err, illegal_err, err_pulse, cycle_count};
    exp = {v.flags, v.cnt};
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s #%0d: got c/s/t/i/p=%b count=%0d, want c/s/t/i/p=%b count=%0d",
               v.name, n_vec, act[20:16], act[15:0], exp[20:16], exp[15:0]);
    end
  endtask

  task automatic step(input string nm, input logic [1:0] ns, input logic [1:0] ew,
                      input bit clr, input bit rst, input logic [4:0] fl, input int cnt);
    vec_t v;
    v.name = nm; v.ns = ns; v.ew = ew; v.clr = clr; v.rst = rst;
    v.flags = fl; v.cnt = 16'(cnt);
    apply(v);
  endtask

  initial begin
    reset = 1'b1; clear_err = 1'b0;
    lights.ns_light = R; lights.ew_light = R;

    // Reset and arm.
    add("reset", R, R, 0, 1, '0, 0);
    add("reset", R, R, 0, 1, '0, 0);
    add("arm",   R, R, 0, 0, '0, 0);

    // Three full legal NS/EW cycles.
    for (int r = 0; r < 3; r++) begin
      ec++;
      for (int k = 0; k < 5; k++) add("legal_ns_g", G, R, 0, 0, '0, ec);
      for (int k = 0; k < 2; k++) add("legal_ns_y", Y, R, 0, 0, '0, ec);
      add("legal_ns_r", R, R, 0, 0, '0, ec);
      for (int k = 0; k < 5; k++) add("legal_ew_g", R, G, 0, 0, '0, ec);
      for (int k = 0; k < 2; k++) add("legal_ew_y", R, Y, 0, 0, '0, ec);
      add("legal_ew_r", R, R, 0, 0, '0, ec);
    end

    // Conflict, then clear_err drops it while EW green->red raises seq (and short green).
    ec++;
    add("conflict",       G, G, 0, 0, f(1, 0, 0, 0, 1), ec);
    add("conflict_clear", G, R, 1, 0, f(0, 1, TON, 0, 1), ec);
    ec = 0;
    add("reset2", R, R, 0, 1, '0, 0);
    add("arm2",   R, R, 0, 0, '0, 0);

    // NS green -> red skips yellow.
    ec++;
    for (int k = 0; k < 5; k++) add("badord_g", G, R, 0, 0, '0, ec);
    add("badord",       R, R, 0, 0, f(0, 1, 0, 0, 1), ec);
    add("badord_hold",  R, R, 0, 0, f(0, 1, 0, 0, 0), ec);
    add("badord_clear", R, R, 1, 0, '0, ec);
    add("badord_idle",  R, R, 0, 0, '0, ec);

    // EW shows 2'b11 while NS green.
    ec++;
    add("illegal_g", G, R, 0, 0, '0, ec);
    add("illegal",   G, X, 0, 0, f(1, 1, 0, 1, 1), ec);
    ec = 0;
    add("reset3", R, R, 0, 1, '0, 0);
    add("arm3",   R, R, 0, 0, '0, 0);

    // clear_err together with a new seq error: error wins.
    ec++;
    for (int k = 0; k < 5; k++) add("clrwin_g", G, R, 0, 0, '0, ec);
    add("clrwin",       R, R, 1, 0, f(0, 1, 0, 0, 1), ec);
    add("clrwin_clear", R, R, 1, 0, '0, ec);

    foreach (tbl[i]) apply(tbl[i]);

    // Reset mid-green: re-armed monitor treats the continuing green as fresh.
    ec++;
    for (int k = 0; k < 3; k++) step("midrst_g", G, R, 0, 0, '0, ec);
    ec = 0;
    step("midrst",     G, R, 0, 1, '0, 0);
    step("midrst_arm", G, R, 0, 0, '0, 0);
    for (int k = 0; k < 4; k++) step("midrst_g2", G, R, 0, 0, '0, 0);
    for (int k = 0; k < 2; k++) step("midrst_y",  Y, R, 0, 0, '0, 0);
    step("midrst_r", R, R, 0, 0, '0, 0);

    // Short green (3 cycles).
    ec++;
    for (int k = 0; k < 3; k++) step("short_g", G, R, 0, 0, '0, ec);
    step("short_leave", Y, R, 0, 0, f(0, 0, TON, 0, TON), ec);
    step("short_y2",    Y, R, 0, 0, f(0, 0, TON, 0, 0), ec);
    step("short_r",     R, R, 0, 0, f(0, 0, TON, 0, 0), ec);
    step("short_clear", R, R, 1, 0, '0, ec);

    // Yellow held 3 cycles.
    ec++;
    for (int k = 0; k < 5; k++) step("longy_g", G, R, 0, 0, '0, ec);
    for (int k = 0; k < 3; k++) step("longy_y", Y, R, 0, 0, '0, ec);
    step("longy_leave", R, R, 0, 0, f(0, 0, TON, 0, TON), ec);
    step("longy_clear", R, R, 1, 0, '0, ec);

    // Green stall: flagged on the 17th green sample, exactly once.
    ec++;
    for (int k = 0; k < 16; k++) step("stall_ok", G, R, 0, 0, '0, ec);
    step("stall_17", G, R, 0, 0, f(0, 0, TON, 0, TON), ec);
    for (int k = 0; k < 3; k++) step("stall_hold", G, R, 0, 0, f(0, 0, TON, 0, 0), ec);
    step("stall_reset", R, R, 0, 1, '0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
